// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: EX-stage operand forwarding, store-data hazard flag and load-use stall sequencing.
// Optional stall-cycle performance counter is enabled by defining HAZ_PERF_CNT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal flow; stall follows the live load-use detect
// HOLD  | extra load-use stall cycles; cnt counts the ones left after this one
module hazard_forward_unit #(
   parameter int RW       = 4,
   parameter int NSRC     = 2,
   parameter int LOAD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 id_valid,
   input  logic [NSRC*RW-1:0]   id_rs,
   input  logic [NSRC-1:0]      id_rs_used,
   input  logic                 ex_valid,
   input  logic [NSRC*RW-1:0]   ex_rs,
   input  logic                 ex_we,
   input  logic                 ex_mr,
   input  logic                 ex_mw,
   input  logic [RW-1:0]        ex_wn,
   input  logic                 mem_we,
   input  logic [RW-1:0]        mem_wn,
   input  logic                 wb_we,
   input  logic [RW-1:0]        wb_wn,
   output logic [2*NSRC-1:0]    fwd_sel,
   output logic                 stall,
   output logic                 bubble,
   output logic                 store_hazard,
   output logic                 store_fwd_mem
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [15:0]          stall_cycles
`endif
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   localparam int         CNT_INIT_I = (LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0;
   localparam logic [1:0] CNT_INIT   = CNT_INIT_I[1:0];

   logic [0:0] state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       store_fwd_mem_q, store_fwd_mem_d;
   logic       load_use;
   logic       stall_c;

   // Store data (source 1) cannot take the MEM result in EX; it is picked up one stage later.
   assign store_hazard = ex_valid && ex_mw && mem_we && (mem_wn != '0)
                         && (ex_rs[RW +: RW] == mem_wn);

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      logic [RW-1:0] rs;
      logic          mem_hit;
      logic          wb_hit;
      logic          force_rf;

      assign rs       = ex_rs[i*RW +: RW];
      assign mem_hit  = ex_valid && mem_we && (mem_wn != '0) && (rs == mem_wn);
      assign wb_hit   = ex_valid && wb_we  && (wb_wn  != '0) && (rs == wb_wn);
      assign force_rf = (i == 1) && store_hazard;

      always_comb begin
         fwd_sel[2*i +: 2] = 2'b00;
         if (mem_hit) begin
            if (!force_rf) begin
               fwd_sel[2*i +: 2] = 2'b10;
            end
         end else if (wb_hit) begin
            fwd_sel[2*i +: 2] = 2'b01;
         end
      end
   end

   always_comb begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (id_rs_used[i] && (id_rs[i*RW +: RW] == ex_wn)) begin
            hit = 1'b1;
         end
      end
      load_use = id_valid && ex_valid && ex_mr && ex_we && (ex_wn != '0) && hit;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_c = 1'b0;
      case (state_q)
         ST_RUN: begin
            stall_c = load_use;
            if (load_use && (LOAD_LAT > 1)) begin
               state_d = ST_HOLD;
               cnt_d   = CNT_INIT;
            end
         end
         ST_HOLD: begin
            stall_c = 1'b1;
            if (cnt_q == 2'd0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
         end
      endcase
   end

   assign stall  = stall_c;
   assign bubble = stall_c;

   // While stalled the MEM stage is not advancing, so the captured flag must hold.
   assign store_fwd_mem_d = stall_c ? store_fwd_mem_q : store_hazard;
   assign store_fwd_mem   = store_fwd_mem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_RUN;
         cnt_q           <= 2'd0;
         store_fwd_mem_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         store_fwd_mem_q <= store_fwd_mem_d;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [15:0] stall_cycles_q, stall_cycles_d;

   assign stall_cycles_d = (stall_c && (stall_cycles_q != 16'hFFFF))
                           ? stall_cycles_q + 16'd1 : stall_cycles_q;
   assign stall_cycles   = stall_cycles_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= 16'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three instances (LOAD_LAT 1/2/3) share stimulus.
// Define HAZ_PERF_CNT_EN to also check the stall-cycle counters.
module tb_hazard_forward_unit;
   localparam int RW   = 4;
   localparam int NSRC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              id_valid, ex_valid, ex_we, ex_mr, ex_mw, mem_we, wb_we;
   logic [NSRC*RW-1:0] id_rs, ex_rs;
   logic [NSRC-1:0]   id_rs_used;
   logic [RW-1:0]     ex_wn, mem_wn, wb_wn;

   logic [3:0] fwd1, fwd2, fwd3;
   logic       stall1, stall2, stall3, bub1, bub2, bub3;
   logic       sh1, sh2, sh3, sfm1, sfm2, sfm3;
`ifdef HAZ_PERF_CNT_EN
   logic [15:0] sc1, sc2, sc3;
`endif

   hazard_forward_unit #(.RW(RW), .NSRC(NSRC), .LOAD_LAT(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_we(ex_we), .ex_mr(ex_mr), .ex_mw(ex_mw),
      .ex_wn(ex_wn), .mem_we(mem_we), .mem_wn(mem_wn), .wb_we(wb_we), .wb_wn(wb_wn),
      .fwd_sel(fwd1), .stall(stall1), .bubble(bub1), .store_hazard(sh1), .store_fwd_mem(sfm1)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cycles(sc1)
`endif
   );
   hazard_forward_unit #(.RW(RW), .NSRC(NSRC), .LOAD_LAT(2)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_we(ex_we), .ex_mr(ex_mr), .ex_mw(ex_mw),
      .ex_wn(ex_wn), .mem_we(mem_we), .mem_wn(mem_wn), .wb_we(wb_we), .wb_wn(wb_wn),
      .fwd_sel(fwd2), .stall(stall2), .bubble(bub2), .store_hazard(sh2), .store_fwd_mem(sfm2)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cycles(sc2)
`endif
   );
   hazard_forward_unit #(.RW(RW), .NSRC(NSRC), .LOAD_LAT(3)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_we(ex_we), .ex_mr(ex_mr), .ex_mw(ex_mw),
      .ex_wn(ex_wn), .mem_we(mem_we), .mem_wn(mem_wn), .wb_we(wb_we), .wb_wn(wb_wn),
      .fwd_sel(fwd3), .stall(stall3), .bubble(bub3), .store_hazard(sh3), .store_fwd_mem(sfm3)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cycles(sc3)
`endif
   );

   typedef struct {
      logic       ex_valid, ex_mw, ex_mr, ex_we;
      logic [3:0] ex_wn, ex_rs0, ex_rs1;
      logic       mem_we;
      logic [3:0] mem_wn;
      logic       wb_we;
      logic [3:0] wb_wn;
      logic       id_valid;
      logic [3:0] id_rs0, id_rs1;
      logic [1:0] id_used;
      logic [3:0] e_fwd;
      logic       e_stall, e_sh;
   } vec_t;

   typedef struct {
      logic [3:0] fwd;
      logic       sh;
      logic       sfm;
      logic [2:0] stall;   // {lat3, lat2, lat1}
      logic [2:0] smask;
      bit         cfwd;
      bit         csfm;
   } exp_t;

   vec_t tbl [22];
   vec_t v_idle, v_lu, v_st;
   exp_t sb [$];
   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   logic m_sfm;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      else n_pass++;
   endtask

   task automatic drive(input vec_t v);
      ex_valid   = v.ex_valid;  ex_mw = v.ex_mw;  ex_mr = v.ex_mr;  ex_we = v.ex_we;
      ex_wn      = v.ex_wn;     ex_rs = {v.ex_rs1, v.ex_rs0};
      mem_we     = v.mem_we;    mem_wn = v.mem_wn;
      wb_we      = v.wb_we;     wb_wn = v.wb_wn;
      id_valid   = v.id_valid;  id_rs = {v.id_rs1, v.id_rs0};
      id_rs_used = v.id_used;
   endtask

   task automatic compare_out();
      exp_t e;
      logic [2:0] st, bb;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e  = sb.pop_front();
      st = {stall3, stall2, stall1};
      bb = {bub3, bub2, bub1};
      if (e.cfwd) begin
         check("fwd_sel_lat1", {28'd0, fwd1}, {28'd0, e.fwd});
         check("fwd_sel_lat3", {28'd0, fwd3}, {28'd0, e.fwd});
         check("store_hazard_lat1", {31'd0, sh1}, {31'd0, e.sh});
         check("store_hazard_lat3", {31'd0, sh3}, {31'd0, e.sh});
      end
      for (int k = 0; k < 3; k++) begin
         if (e.smask[k]) begin
            check($sformatf("stall_lat%0d", k + 1), {31'd0, st[k]}, {31'd0, e.stall[k]});
            check($sformatf("bubble_lat%0d", k + 1), {31'd0, bb[k]}, {31'd0, e.stall[k]});
         end
      end
      if (e.csfm) check("store_fwd_mem_lat1", {31'd0, sfm1}, {31'd0, e.sfm});
   endtask

   task automatic step(input vec_t v, input exp_t e);
      @(posedge clk);
      #1;
      cyc++;
      drive(v);
      sb.push_back(e);
      @(negedge clk);
      compare_out();
   endtask

   function automatic exp_t mkexp(input logic [2:0] stall, input logic [2:0] mask);
      exp_t e;
      e.fwd = 4'd0; e.sh = 1'b0; e.sfm = 1'b0;
      e.stall = stall; e.smask = mask; e.cfwd = 1'b0; e.csfm = 1'b0;
      return e;
   endfunction

   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      exp_t e;
      //         v  mw mr we wn rs0 rs1 mwe mwn wwe wwn idv irs0 irs1 used   fwd      st sh
      tbl[0]  = '{0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0,   2'b00, 4'b0000, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 0, 3,  9,  1,  3,  1,  3,  0,  0,   0,   2'b00, 4'b0010, 0, 0};
      tbl[2]  = '{1, 0, 0, 0, 0, 3,  9,  0,  3,  1,  3,  0,  0,   0,   2'b00, 4'b0001, 0, 0};
      tbl[3]  = '{1, 0, 0, 0, 0, 0,  0,  1,  0,  1,  0,  0,  0,   0,   2'b00, 4'b0000, 0, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 3,  3,  1,  3,  1,  3,  0,  0,   0,   2'b00, 4'b0000, 0, 0};
      tbl[5]  = '{1, 0, 0, 0, 0, 4,  6,  1,  6,  1,  4,  0,  0,   0,   2'b00, 4'b1001, 0, 0};
      tbl[6]  = '{1, 1, 0, 0, 0, 7,  7,  1,  7,  0,  0,  0,  0,   0,   2'b00, 4'b0010, 0, 1};
      tbl[7]  = '{1, 1, 0, 0, 0, 0,  8,  1,  2,  1,  8,  0,  0,   0,   2'b00, 4'b0100, 0, 0};
      tbl[8]  = '{0, 1, 0, 0, 0, 0,  7,  1,  7,  0,  0,  0,  0,   0,   2'b00, 4'b0000, 0, 0};
      tbl[9]  = '{1, 0, 1, 1, 5, 0,  0,  0,  0,  0,  0,  1,  0,   5,   2'b10, 4'b0000, 1, 0};
      tbl[10] = '{1, 0, 1, 1, 5, 0,  0,  0,  0,  0,  0,  1,  2,   5,   2'b01, 4'b0000, 0, 0};
      tbl[11] = '{1, 0, 1, 1, 0, 0,  0,  0,  0,  0,  0,  1,  0,   0,   2'b11, 4'b0000, 0, 0};
      tbl[12] = '{1, 0, 1, 0, 5, 0,  0,  0,  0,  0,  0,  1,  5,   5,   2'b11, 4'b0000, 0, 0};
      tbl[13] = '{1, 0, 1, 1, 5, 0,  0,  0,  0,  0,  0,  0,  5,   5,   2'b11, 4'b0000, 0, 0};
      tbl[14] = '{1, 0, 1, 1, 5, 0,  0,  0,  0,  0,  0,  1,  5,   0,   2'b01, 4'b0000, 1, 0};
      tbl[15] = '{1, 0, 0, 1, 5, 0,  0,  0,  0,  0,  0,  1,  5,   5,   2'b11, 4'b0000, 0, 0};
      tbl[16] = '{0, 0, 1, 1, 5, 0,  0,  0,  0,  0,  0,  1,  5,   5,   2'b11, 4'b0000, 0, 0};
      tbl[17] = '{1, 1, 1, 1, 5, 0,  7,  1,  7,  0,  0,  1,  0,   5,   2'b10, 4'b0000, 1, 1};
      tbl[18] = '{0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0,   2'b00, 4'b0000, 0, 0};
      tbl[19] = '{1, 1, 0, 0, 0, 0,  7,  1,  7,  0,  0,  0,  0,   0,   2'b00, 4'b0000, 0, 1};
      tbl[20] = '{1, 0, 1, 1, 5, 0,  0,  0,  0,  0,  0,  1,  0,   5,   2'b10, 4'b0000, 1, 0};
      tbl[21] = '{0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0,   2'b00, 4'b0000, 0, 0};
      v_idle = tbl[0];
      v_lu   = tbl[9];
      v_st   = tbl[19];

      // Reset state
      drive(v_idle);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_stall", {29'd0, stall3, stall2, stall1}, 32'd0);
      check("reset_sfm", {29'd0, sfm3, sfm2, sfm1}, 32'd0);
      check("reset_fwd", {20'd0, fwd3, fwd2, fwd1}, 32'd0);
      rst_n = 1'b1;

      // Table vectors; store_fwd_mem follows the previous cycle's flag unless stalled
      m_sfm = 1'b0;
      for (int i = 0; i < 22; i++) begin
         e       = mkexp({3{tbl[i].e_stall}}, 3'b001);
         e.fwd   = tbl[i].e_fwd;
         e.sh    = tbl[i].e_sh;
         e.cfwd  = 1'b1;
         e.csfm  = 1'b1;
         e.sfm   = m_sfm;
         step(tbl[i], e);
         m_sfm = tbl[i].e_stall ? m_sfm : tbl[i].e_sh;
      end
      repeat (3) step(v_idle, mkexp(3'b000, 3'b000));
      step(v_idle, mkexp(3'b000, 3'b111));

      // Single load-use event: each instance stalls exactly LOAD_LAT cycles
      step(v_lu,   mkexp(3'b111, 3'b111));
      step(v_idle, mkexp(3'b110, 3'b111));
      step(v_idle, mkexp(3'b100, 3'b111));
      step(v_idle, mkexp(3'b000, 3'b111));
      step(v_idle, mkexp(3'b000, 3'b111));

      // Second event right after LAT2 returns to RUN; LAT3 is still in HOLD and ignores it
      step(v_lu,   mkexp(3'b111, 3'b111));
      step(v_idle, mkexp(3'b110, 3'b111));
      step(v_lu,   mkexp(3'b111, 3'b111));
      step(v_idle, mkexp(3'b010, 3'b111));
      step(v_idle, mkexp(3'b000, 3'b111));

      // Reset during the second HOLD cycle of LAT3
      e = mkexp(3'b000, 3'b111);
      e.sh = 1'b1; e.cfwd = 1'b1;
      step(v_st,   e);
      step(v_lu,   mkexp(3'b111, 3'b111));
      step(v_idle, mkexp(3'b110, 3'b111));
      step(v_idle, mkexp(3'b100, 3'b111));
      check("sfm_before_reset_lat3", {31'd0, sfm3}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("stall_in_reset_lat3", {31'd0, stall3}, 32'd0);
      check("sfm_in_reset", {29'd0, sfm3, sfm2, sfm1}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(v_idle, mkexp(3'b000, 3'b111));
      step(v_lu,   mkexp(3'b111, 3'b111));
      step(v_idle, mkexp(3'b110, 3'b111));
      step(v_idle, mkexp(3'b100, 3'b111));
      step(v_idle, mkexp(3'b000, 3'b111));

      // Two separated events from a clean reset
      reset_pulse();
      step(v_lu,   mkexp(3'b111, 3'b111));
      step(v_idle, mkexp(3'b110, 3'b111));
      step(v_idle, mkexp(3'b100, 3'b111));
      step(v_lu,   mkexp(3'b111, 3'b111));
      step(v_idle, mkexp(3'b110, 3'b111));
      step(v_idle, mkexp(3'b100, 3'b111));
      step(v_idle, mkexp(3'b000, 3'b111));
`ifdef HAZ_PERF_CNT_EN
      check("stall_cycles_lat1", {16'd0, sc1}, 32'd2);
      check("stall_cycles_lat2", {16'd0, sc2}, 32'd4);
      check("stall_cycles_lat3", {16'd0, sc3}, 32'd6);
`endif
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter RW, default 4, register-number width.
REQ-002 SHALL have parameter NSRC, default 2, source operands per instruction; legal 2..3; source 1 is store-data source.
REQ-003 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles; legal 1..3.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port id_valid, input, 1, ID-stage instruction valid.
REQ-008 SHALL have port id_rs, input, NSRC*RW, ID source registers; source i in bits [i*RW +: RW].
REQ-009 SHALL have port id_rs_used, input, NSRC, per-source "operand read" flags for ID.
REQ-010 SHALL have port ex_valid, input, 1, EX-stage instruction valid.
REQ-011 SHALL have port ex_rs, input, NSRC*RW, EX source registers.
REQ-012 SHALL have ports ex_we/ex_mr/ex_mw, input, 1 each, EX register-write, memory-read (load), memory-write (store).
REQ-013 SHALL have port ex_wn, input, RW, EX destination register.
REQ-014 SHALL have ports mem_we/wb_we, input, 1 each, and mem_wn/wb_wn, input, RW each, MEM and WB write enable and destination.
REQ-015 SHALL have port fwd_sel, output, 2*NSRC, per-source select: 00 register file, 10 MEM result, 01 WB result.
REQ-016 SHALL have port stall, output, 1, hold PC and IF/ID register.
REQ-017 SHALL have port bubble, output, 1, load NOP into ID/EX; always equal to stall.
REQ-018 SHALL have port store_hazard, output, 1, EX store data depends on MEM-stage writer.
REQ-019 SHALL have port store_fwd_mem, output, 1, registered; MEM-stage store data taken from WB result.

Function
REQ-020 SHALL set fwd_sel[i]=10 when ex_valid & mem_we & mem_wn!=0 & ex_rs[i]==mem_wn; else 01 when ex_valid & wb_we & wb_wn!=0 & ex_rs[i]==wb_wn; else 00; MEM has priority.
REQ-021 SHALL never forward register 0 under any combination of inputs.
REQ-022 SHALL, when ex_valid & ex_mw & source 1 meets the MEM condition of REQ-020, assert store_hazard and force fwd_sel[1]=00 combinationally; other sources unaffected.
REQ-023 SHALL register store_fwd_mem <= store_hazard every cycle while stall=0; hold its value while stall=1.
REQ-024 SHALL detect load-use as id_valid & ex_valid & ex_mr & ex_we & ex_wn!=0 & any i with id_rs_used[i] & id_rs[i]==ex_wn.
REQ-025 SHALL implement FSM states RUN and HOLD plus a 2-bit down-counter cnt.
REQ-026 SHALL, in RUN, drive stall = load-use (combinational, same cycle); if load-use and LOAD_LAT>1, go to HOLD with cnt=LOAD_LAT-2; otherwise stay RUN.
REQ-027 SHALL, in HOLD, drive stall=1 and ignore load-use detection; when cnt==0 return to RUN, else decrement cnt.
REQ-028 SHALL produce exactly LOAD_LAT consecutive stall cycles per load-use event.
REQ-029 SHALL treat a load-use event in the cycle immediately after returning to RUN as a new event.
REQ-030 SHALL drive all outputs only from the current cycle's inputs, state and cnt; forwarding outputs have no latency.

Reset
REQ-031 SHALL, on rst_n low, asynchronously force state RUN, cnt=0, store_fwd_mem=0, and the perf counter to 0.
REQ-032 SHALL, after reset mid-HOLD, resume in RUN with stall driven only by current inputs.

Configuration
REQ-033 SHALL, with macro HAZ_PERF_CNT_EN defined, add output stall_cycles, 16 bits, incremented each clock with stall=1 and saturating at 16'hFFFF.
REQ-034 SHALL, without HAZ_PERF_CNT_EN, omit the stall_cycles port and counter with otherwise identical behaviour.

Verification
REQ-035 SHALL test: ex_rs[0]=3, mem_we=1, mem_wn=3, wb_we=1, wb_wn=3 -> fwd_sel[1:0]=10; with mem_we=0 -> 01.
REQ-036 SHALL test: ex_rs[0]=0, mem_we=1, mem_wn=0 -> fwd_sel[1:0]=00.
REQ-037 SHALL test: LOAD_LAT=3, ex_mr=1, ex_wn=5, id_rs[1]=5, id_rs_used=2'b10 -> stall high exactly 3 cycles, then low.
REQ-038 SHALL test: ex_mw=1, ex_rs[1]=7, mem_we=1, mem_wn=7 -> store_hazard=1, fwd_sel[3:2]=00, store_fwd_mem=1 next cycle.
REQ-039 SHALL test: rst_n low during the second HOLD cycle -> stall drops immediately; store_fwd_mem=0.
REQ-040 SHALL test: HAZ_PERF_CNT_EN defined, two LOAD_LAT=2 events -> stall_cycles=4.
